// File: rtl/tmds_channel_rx_pkg.sv
// tmds_pkg: shared definitions for the TMDS receive channel.
//   - the four 10-bit control tokens as they appear on din (bit0 first on wire)
//   - rx_state_t: alignment FSM states
//   - token_map(): classifies a word, returning {is_token, c1, c0}
package tmds_pkg;

  localparam logic [9:0] TOK_CTL00 = 10'h354;
  localparam logic [9:0] TOK_CTL01 = 10'h0AB;
  localparam logic [9:0] TOK_CTL10 = 10'h154;
  localparam logic [9:0] TOK_CTL11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } rx_state_t;

  function automatic logic [2:0] token_map(input logic [9:0] w);
    case (w)
      TOK_CTL00: token_map = 3'b100;
      TOK_CTL01: token_map = 3'b101;
      TOK_CTL10: token_map = 3'b110;
      TOK_CTL11: token_map = 3'b111;
      default:   token_map = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tmds_channel_rx_if.sv
// tmds_channel_rx_if: word/alignment/decode bundle of one TMDS receive channel.
//   din        10  deserialized word from the deserializer
//   bitslip     1  alignment shift request back to the deserializer
//   locked      1  word alignment acquired
//   de          1  dout carries pixel data (else ctl carries control value)
//   dout        8  decoded pixel byte
//   ctl         2  decoded control value {c1,c0}
//   relock_cnt  8  lock-loss count, present only with TMDS_RELOCK_CNT_EN
// Modports: slave = the receiver, master = deserializer / downstream side.
interface tmds_channel_rx_if;
  logic [9:0] din;
  logic       bitslip;
  logic       locked;
  logic       de;
  logic [7:0] dout;
  logic [1:0] ctl;
`ifdef TMDS_RELOCK_CNT_EN
  logic [7:0] relock_cnt;

  modport slave  (input din, output bitslip, locked, de, dout, ctl, relock_cnt);
  modport master (output din, input bitslip, locked, de, dout, ctl, relock_cnt);
`else
  modport slave  (input din, output bitslip, locked, de, dout, ctl);
  modport master (output din, input bitslip, locked, de, dout, ctl);
`endif
endinterface

// File: rtl/tmds_word_decode.sv
// tmds_word_decode: combinational TMDS word classifier and data decoder.
//   din      in   10  TMDS word
//   is_token out   1  din is one of the four control tokens
//   ctl      out   2  control value for a token (0 otherwise)
//   q        out   8  decoded data byte (meaningful only for data words)
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] din,
  output logic       is_token,
  output logic [1:0] ctl,
  output logic [7:0] q
);

  logic [7:0] t;

  always_comb begin
    {is_token, ctl} = token_map(din);
    // din[9] marks an inverted byte; din[8] selects XOR vs XNOR chaining
    t = din[9] ? ~din[7:0] : din[7:0];
    if (din[8]) q = {t[7:1] ^ t[6:0], t[0]};
    else        q = {~(t[7:1] ^ t[6:0]), t[0]};
  end

endmodule

// File: rtl/tmds_channel_rx.sv
// tmds_channel_rx: one TMDS receive channel with word alignment search.
//   clk_vga  in  pixel clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   bus      slave modport of tmds_channel_rx_if (din in; bitslip, locked,
//            de, dout, ctl and optionally relock_cnt out)
// The FSM hunts for runs of identical control tokens, pulsing bitslip after
// each fruitless search window, and drops lock when tokens stop arriving.
// Optional feature macro: TMDS_RELOCK_CNT_EN adds a saturating lock-loss
// counter on bus.relock_cnt.
module tmds_channel_rx
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN    = 8,
  parameter int SEARCH_WIN   = 1024,
  parameter int SLIP_SETTLE  = 4,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic            clk_vga,
  input  logic            rst_n,
  tmds_channel_rx_if.slave bus
);

  localparam int RUN_W = $clog2(TOKEN_RUN) + 1;
  localparam int WIN_W = $clog2(SEARCH_WIN) + 1;
  localparam int SET_W = $clog2(SLIP_SETTLE) + 1;
  localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TOKEN_RUN - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WIN - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

  // Stage p0: combinational decode of the incoming word
  logic       tok_p0;
  logic [1:0] ctl_p0;
  logic [7:0] q_p0;

  tmds_word_decode u_decode (
    .din      (bus.din),
    .is_token (tok_p0),
    .ctl      (ctl_p0),
    .q        (q_p0)
  );

  rx_state_t        state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt;
  logic [1:0]       last_tok, last_tok_nxt;
  logic [WIN_W-1:0] win_cnt, win_nxt;
  logic [SET_W-1:0] set_cnt, set_nxt;
  logic [TO_W-1:0]  to_cnt, to_nxt;

  always_comb begin
    state_nxt    = state;
    run_nxt      = run_cnt;
    last_tok_nxt = last_tok;
    win_nxt      = win_cnt;
    set_nxt      = set_cnt;
    to_nxt       = to_cnt;
    case (state)
      SEARCH: begin
        win_nxt = win_cnt + WIN_W'(1);
        if (tok_p0) begin
          last_tok_nxt = ctl_p0;
          // run_cnt holds the length of the current identical-token run
          if (run_cnt != '0 && ctl_p0 == last_tok) begin
            if (run_cnt == RUN_LAST) begin
              state_nxt = LOCKED;
              to_nxt    = '0;
            end else begin
              run_nxt = run_cnt + RUN_W'(1);
            end
          end else begin
            run_nxt = RUN_W'(1);
          end
        end else begin
          run_nxt = '0;
        end
        // a run completing on the window's last cycle takes priority
        if (state_nxt != LOCKED && win_cnt == WIN_LAST) state_nxt = SLIP;
      end
      SLIP: begin
        state_nxt = SETTLE;
        set_nxt   = '0;
      end
      SETTLE: begin
        if (set_cnt == SET_LAST) begin
          state_nxt = SEARCH;
          set_nxt   = '0;
          run_nxt   = '0;
          win_nxt   = '0;
        end else begin
          set_nxt = set_cnt + SET_W'(1);
        end
      end
      LOCKED: begin
        if (tok_p0) begin
          to_nxt = '0;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = SEARCH;
          to_nxt    = '0;
          run_nxt   = '0;
          win_nxt   = '0;
        end else begin
          to_nxt = to_cnt + TO_W'(1);
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Stage p1: FSM state and registered outputs
  logic       bitslip_p1;
  logic       locked_p1;
  logic       de_p1;
  logic [7:0] dout_p1;
  logic [1:0] ctl_p1;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      run_cnt    <= '0;
      last_tok   <= '0;
      win_cnt    <= '0;
      set_cnt    <= '0;
      to_cnt     <= '0;
      bitslip_p1 <= 1'b0;
      locked_p1  <= 1'b0;
      de_p1      <= 1'b0;
      dout_p1    <= '0;
      ctl_p1     <= '0;
    end else begin
      state      <= state_nxt;
      run_cnt    <= run_nxt;
      last_tok   <= last_tok_nxt;
      win_cnt    <= win_nxt;
      set_cnt    <= set_nxt;
      to_cnt     <= to_nxt;
      bitslip_p1 <= (state_nxt == SLIP);
      locked_p1  <= (state_nxt == LOCKED);
      if (tok_p0) begin
        de_p1  <= 1'b0;
        ctl_p1 <= ctl_p0;
      end else begin
        // outside lock the byte still updates for debug, but de stays low
        de_p1   <= (state_nxt == LOCKED);
        dout_p1 <= q_p0;
      end
    end
  end

  assign bus.bitslip = bitslip_p1;
  assign bus.locked  = locked_p1;
  assign bus.de      = de_p1;
  assign bus.dout    = dout_p1;
  assign bus.ctl     = ctl_p1;

`ifdef TMDS_RELOCK_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] relock_p1;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n)
      relock_p1 <= '0;
    else if (state == LOCKED && state_nxt == SEARCH)
      relock_p1 <= sat_inc8(relock_p1);
  end

  assign bus.relock_cnt = relock_p1;
`endif

endmodule

// File: tb/tb_tmds_channel_rx.sv
module tb_tmds_channel_rx;

  localparam logic [9:0] T00 = 10'h354;
  localparam logic [9:0] T01 = 10'h0AB;
  localparam logic [9:0] T10 = 10'h154;
  localparam logic [9:0] T11 = 10'h2AB;
  localparam int PERIOD = 1024 + 4 + 1;

  logic clk_vga = 1'b0;
  logic rst_n   = 1'b0;
  int   tests   = 0;
  int   fails   = 0;

  tmds_channel_rx_if bus();

  tmds_channel_rx dut (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  function automatic logic [9:0] rot(input logic [9:0] w, input int s);
    logic [19:0] d;
    d = {w, w};
    return d[s +: 10];
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.din = 10'h000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.din = T00;
    tick();
    tick();
    tests++; if (bus.bitslip !== 1'b0) begin fails++; $display("FAIL reset_bitslip got %b want 0", bus.bitslip); end
    tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL reset_locked got %b want 0", bus.locked); end
    tests++; if (bus.de !== 1'b0) begin fails++; $display("FAIL reset_de got %b want 0", bus.de); end
    tests++; if (bus.dout !== 8'h00) begin fails++; $display("FAIL reset_dout got %h want 00", bus.dout); end
    tests++; if (bus.ctl !== 2'b00) begin fails++; $display("FAIL reset_ctl got %b want 00", bus.ctl); end
`ifdef TMDS_RELOCK_CNT_EN
    tests++; if (bus.relock_cnt !== 8'd0) begin fails++; $display("FAIL reset_relock got %0d want 0", bus.relock_cnt); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_aligned_lock();
    int slips = 0;
    for (int k = 1; k <= 8; k++) begin
      bus.din = T00;
      tick();
      if (bus.bitslip === 1'b1) slips++;
      if (k == 7) begin
        tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL lock_early got %b want 0", bus.locked); end
      end
    end
    tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL lock_aligned got %b want 1", bus.locked); end
    tests++; if (bus.ctl !== 2'b00) begin fails++; $display("FAIL lock_ctl got %b want 00", bus.ctl); end
    tests++; if (bus.de !== 1'b0) begin fails++; $display("FAIL lock_de got %b want 0", bus.de); end
    tests++; if (slips != 0) begin fails++; $display("FAIL lock_noslip got %0d pulses want 0", slips); end
  endtask

  task automatic test_data_decode();
    bus.din = 10'h1FF;
    tick();
    tests++; if (bus.de !== 1'b1 || bus.dout !== 8'h01) begin fails++; $display("FAIL dec_1ff got de=%b dout=%h want de=1 dout=01", bus.de, bus.dout); end
    bus.din = 10'h2FF;
    tick();
    tests++; if (bus.de !== 1'b1 || bus.dout !== 8'hFE) begin fails++; $display("FAIL dec_2ff got de=%b dout=%h want de=1 dout=fe", bus.de, bus.dout); end
    bus.din = T01;
    tick();
    tests++; if (bus.de !== 1'b0 || bus.ctl !== 2'b01 || bus.dout !== 8'hFE) begin fails++; $display("FAIL tok_hold got de=%b ctl=%b dout=%h want de=0 ctl=01 dout=fe", bus.de, bus.ctl, bus.dout); end
    bus.din = 10'h3F0;
    tick();
    tests++; if (bus.de !== 1'b1 || bus.dout !== 8'h11 || bus.ctl !== 2'b01) begin fails++; $display("FAIL dec_3f0 got de=%b dout=%h ctl=%b want de=1 dout=11 ctl=01", bus.de, bus.dout, bus.ctl); end
    tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL dec_locked got %b want 1", bus.locked); end
  endtask

  task automatic test_timeout();
    bus.din = T00;
    tick();
    for (int k = 1; k <= 4096; k++) begin
      bus.din = 10'h1FF;
      tick();
      if (k == 4095) begin
        tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL to_early got %b want 1", bus.locked); end
      end
    end
    tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL to_drop got %b want 0", bus.locked); end
    tests++; if (bus.de !== 1'b0 || bus.dout !== 8'h01) begin fails++; $display("FAIL to_de got de=%b dout=%h want de=0 dout=01", bus.de, bus.dout); end
`ifdef TMDS_RELOCK_CNT_EN
    tests++; if (bus.relock_cnt !== 8'd1) begin fails++; $display("FAIL to_relock got %0d want 1", bus.relock_cnt); end
`endif
    for (int k = 1; k <= 8; k++) begin
      bus.din = T10;
      tick();
      if (k == 7) begin
        tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL relock_early got %b want 0", bus.locked); end
      end
    end
    tests++; if (bus.locked !== 1'b1 || bus.ctl !== 2'b10) begin fails++; $display("FAIL relock got locked=%b ctl=%b want 1 10", bus.locked, bus.ctl); end
  endtask

  task automatic test_slip_align();
    int off = 7;
    int pulses = 0;
    int last_p = -1;
    int bad_gap = 0;
    int lock_cyc = -1;
    do_reset();
    for (int c = 1; c <= 5000; c++) begin
      bus.din = rot(T00, off % 10);
      tick();
      if (bus.bitslip === 1'b1) begin
        pulses++;
        if (last_p >= 0 && (c - last_p) != PERIOD) bad_gap++;
        if (last_p < 0 && c != 1024) bad_gap++;
        last_p = c;
        off++;
      end
      if (bus.locked === 1'b1) begin
        lock_cyc = c;
        break;
      end
    end
    tests++; if (pulses != 3) begin fails++; $display("FAIL slip_count got %0d want 3", pulses); end
    tests++; if (bad_gap != 0) begin fails++; $display("FAIL slip_gap got %0d bad gaps want 0", bad_gap); end
    tests++; if (lock_cyc < 0 || lock_cyc - last_p != 13) begin fails++; $display("FAIL slip_lock got %0d cycles after last slip want 13", lock_cyc - last_p); end
  endtask

  task automatic test_reset_mid_settle();
    int seen = 0;
    do_reset();
    for (int c = 1; c <= 1100; c++) begin
      bus.din = rot(T00, 1);
      tick();
      if (bus.bitslip === 1'b1) begin
        seen = 1;
        break;
      end
    end
    tests++; if (seen != 1) begin fails++; $display("FAIL mid_slip_seen got %0d want 1", seen); end
    tick();
    tick();
    tests++; if (bus.dout !== 8'hFE) begin fails++; $display("FAIL unlocked_dout got %h want fe", bus.dout); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if ({bus.bitslip, bus.locked, bus.de, bus.dout, bus.ctl} !== 13'd0) begin
      fails++;
      $display("FAIL async_reset got bs=%b lk=%b de=%b dout=%h ctl=%b want all 0", bus.bitslip, bus.locked, bus.de, bus.dout, bus.ctl);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      bus.din = T11;
      tick();
      if (k == 7) begin
        tests++; if (bus.locked !== 1'b0) begin fails++; $display("FAIL post_rst_early got %b want 0", bus.locked); end
      end
    end
    tests++; if (bus.locked !== 1'b1 || bus.ctl !== 2'b11) begin fails++; $display("FAIL post_rst_lock got locked=%b ctl=%b want 1 11", bus.locked, bus.ctl); end
  endtask

  task automatic test_alternating();
    int pulses = 0;
    int last_p = -1;
    int bad_gap = 0;
    int lk = 0;
    int consec = 0;
    logic prev_bs = 1'b0;
    do_reset();
    for (int c = 1; c <= 3200; c++) begin
      bus.din = c[0] ? T00 : T01;
      tick();
      if (bus.locked === 1'b1) lk++;
      if (bus.bitslip === 1'b1) begin
        if (prev_bs) consec++;
        pulses++;
        if (last_p < 0 && c != 1024) bad_gap++;
        if (last_p >= 0 && (c - last_p) != PERIOD) bad_gap++;
        last_p = c;
      end
      prev_bs = bus.bitslip;
    end
    tests++; if (lk != 0) begin fails++; $display("FAIL alt_locked got %0d locked cycles want 0", lk); end
    tests++; if (pulses != 3) begin fails++; $display("FAIL alt_pulses got %0d want 3", pulses); end
    tests++; if (bad_gap != 0 || consec != 0) begin fails++; $display("FAIL alt_gap got %0d bad gaps %0d consecutive want 0 0", bad_gap, consec); end
  endtask

  task automatic test_lock_vs_slip();
    int slips = 0;
    do_reset();
    for (int c = 1; c <= 1024; c++) begin
      bus.din = (c <= 1016) ? 10'h1AA : T00;
      tick();
      if (bus.bitslip === 1'b1) slips++;
    end
    tests++; if (bus.locked !== 1'b1) begin fails++; $display("FAIL race_lock got %b want 1", bus.locked); end
    bus.din = T00;
    tick();
    if (bus.bitslip === 1'b1) slips++;
    tests++; if (slips != 0 || bus.locked !== 1'b1) begin fails++; $display("FAIL race_slip got %0d pulses locked=%b want 0 1", slips, bus.locked); end
  endtask

  initial begin
    bus.din = 10'h000;
    test_reset();
    test_aligned_lock();
    test_data_decode();
    test_timeout();
    test_slip_align();
    test_reset_mid_settle();
    test_alternating();
    test_lock_vs_slip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
